fifo_stat: RTL and testbench



---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 29 ++
 rtl/fifo_stat.sv | 160 ++++++++++++++++
 tb/tb_fifo_stat.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_stat queue: read-mode selector and
// count-width calculation.
package fifo_pkg;

    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // A counter that must hold 0..depth inclusive needs one more code than depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Storage array for fifo_stat: synchronous write port, asynchronous read port.
// Contents are undefined until written; the pointer logic guards every read.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset on purpose; clearing it would turn a plain
    // register file into DEPTH*DATA_WIDTH resettable flops for no functional gain.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/fifo_stat.sv
// Synchronous FIFO with occupancy count, almost-full/empty flags, sticky
// overflow/underflow, synchronous flush and registered or fall-through read.
module fifo_stat
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int       DEPTH   = 1 << ADDR_WIDTH;
    localparam int       CNT_W   = count_width(DEPTH);
    localparam rd_mode_e RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REG;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL >= 1 && AF_LEVEL <= DEPTH))
    begin : g_bad_levels
        $error("fifo_stat: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    if (CNT_W != ADDR_WIDTH + 1) begin : g_bad_count_width
        $error("fifo_stat: count width does not match ADDR_WIDTH+1");
    end

    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read frees a slot in the same edge, so a full FIFO still takes a write
    // when it is also being read. Flush suppresses both transfers.
    assign pop  = rd & ~empty & ~flush;
    assign push = wr & (~full | pop) & ~flush;

    // NOTE: every signal driven here gets its default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_d     = count_q;
        w_addr_d    = w_addr_q;
        r_addr_d    = r_addr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            count_d     = '0;
            w_addr_d    = '0;
            r_addr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                w_addr_d = w_addr_q + PTR_ONE;
            end
            if (pop) begin
                r_addr_d = r_addr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
            if (wr && full && !pop) begin
                overflow_d = 1'b1;
            end
            if (rd && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            w_addr_q    <= '0;
            r_addr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            w_addr_q    <= w_addr_d;
            r_addr_q    <= r_addr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (push),
        .waddr_i(w_addr_q),
        .wdata_i(w_data),
        .raddr_i(r_addr_q),
        .rdata_o(mem_rdata)
    );

    if (RD_MODE == RD_REG) begin : g_rd_reg
        logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
        logic                  r_valid_q, r_valid_d;

        assign r_valid_d = pop;
        assign r_data_d  = pop ? mem_rdata : r_data_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_data_q  <= r_data_d;
                r_valid_q <= r_valid_d;
            end
        end

        assign r_data  = r_data_q;
        assign r_valid = r_valid_q;
    end else begin : g_rd_fwft
        // Masking on empty keeps never-written memory off the output.
        assign r_valid = ~empty;
        assign r_data  = empty ? '0 : mem_rdata;
    end

endmodule : fifo_stat

// File: tb/tb_fifo_stat.sv
// Directed bench for fifo_stat: a registered-read and a fall-through instance
// share one stimulus stream and are checked against hand-computed vectors.
module tb_fifo_stat;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          wr;
    logic          rd;
    logic [DW-1:0] w_data;

    logic [DW-1:0] r_data_r, r_data_f;
    logic          r_valid_r, r_valid_f;
    logic          empty_r, empty_f, full_r, full_f;
    logic          ae_r, ae_f, af_r, af_f;
    logic [AW:0]   count_r, count_f;
    logic          ov_r, ov_f, uf_r, uf_f;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_stat #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut_reg (
        .clk(clk), .reset(reset), .flush(flush), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data_r), .r_valid(r_valid_r), .empty(empty_r), .full(full_r),
        .almost_empty(ae_r), .almost_full(af_r), .count(count_r),
        .overflow(ov_r), .underflow(uf_r)
    );

    fifo_stat #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_fw (
        .clk(clk), .reset(reset), .flush(flush), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data_f), .r_valid(r_valid_f), .empty(empty_f), .full(full_f),
        .almost_empty(ae_f), .almost_full(af_f), .count(count_f),
        .overflow(ov_f), .underflow(uf_f)
    );

    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rd;
        logic          fl;
        int            cnt;
        logic          ov;
        logic          uf;
        logic          rv;   // registered-read r_valid
        logic [DW-1:0] rq;   // registered-read r_data
        logic [DW-1:0] fh;   // fall-through r_data (head, 0 when empty)
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Flags are derived from the hand-computed count with AE=1, AF=3, DEPTH=4.
    task automatic check_state(input string tag, input int cnt, input logic ov, input logic uf,
                               input logic rv, input logic [DW-1:0] rq, input logic [DW-1:0] fh);
        check({tag, " reg.count"}, 32'(count_r), cnt);
        check({tag, " fw.count"}, 32'(count_f), cnt);
        check({tag, " reg.empty"}, 32'(empty_r), 32'(cnt == 0));
        check({tag, " fw.empty"}, 32'(empty_f), 32'(cnt == 0));
        check({tag, " reg.full"}, 32'(full_r), 32'(cnt == 4));
        check({tag, " fw.full"}, 32'(full_f), 32'(cnt == 4));
        check({tag, " reg.almost_empty"}, 32'(ae_r), 32'(cnt <= 1));
        check({tag, " fw.almost_empty"}, 32'(ae_f), 32'(cnt <= 1));
        check({tag, " reg.almost_full"}, 32'(af_r), 32'(cnt >= 3));
        check({tag, " fw.almost_full"}, 32'(af_f), 32'(cnt >= 3));
        check({tag, " reg.overflow"}, 32'(ov_r), 32'(ov));
        check({tag, " fw.overflow"}, 32'(ov_f), 32'(ov));
        check({tag, " reg.underflow"}, 32'(uf_r), 32'(uf));
        check({tag, " fw.underflow"}, 32'(uf_f), 32'(uf));
        check({tag, " reg.r_valid"}, 32'(r_valid_r), 32'(rv));
        check({tag, " reg.r_data"}, 32'(r_data_r), 32'(rq));
        check({tag, " fw.r_valid"}, 32'(r_valid_f), 32'(cnt != 0));
        check({tag, " fw.r_data"}, 32'(r_data_f), 32'(fh));
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        wr     = w;
        w_data = d;
        rd     = r;
        flush  = f;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [26];

    initial begin
        vecs = '{
            // fill to full, then a dropped write while full
            '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11},
            '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11},
            '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11},
            '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11},
            '{1'b1, 8'h55, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11},
            // drain in order; overflow stays sticky
            '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22},
            '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1, 8'h22, 8'h33},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 8'h33, 8'h44},
            '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h00},
            '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h00},
            // refill, then simultaneous read+write while full
            '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h44, 8'h11},
            '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h44, 8'h11},
            '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h44, 8'h11},
            '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 8'h44, 8'h11},
            '{1'b1, 8'h66, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22},
            '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 8'h22, 8'h33},
            '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'h33, 8'h44},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h44, 8'h66},
            '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h66, 8'h00},
            // read while empty, then flush clears underflow
            '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h66, 8'h00},
            '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h66, 8'h00},
            // flush wins over a same-cycle write
            '{1'b1, 8'h77, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h66, 8'h77},
            '{1'b1, 8'h88, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h66, 8'h77},
            '{1'b1, 8'h99, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h66, 8'h00},
            '{1'b1, 8'hAA, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h66, 8'hAA},
            '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'hAA, 8'h00}
        };

        reset  = 1'b0;
        flush  = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        #12;
        check_state("reset", 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].fl);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].uf,
                        vecs[i].rv, vecs[i].rq, vecs[i].fh);
        end

        // Alternating write/read pairs walk both pointers past the wrap point.
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] prev;
            prev = (i == 0) ? 8'hAA : 8'(i - 1);
            step(1'b1, 8'(i), 1'b0, 1'b0);
            check_state($sformatf("wrap%0d.wr", i), 1, 1'b0, 1'b0, 1'b0, prev, 8'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check_state($sformatf("wrap%0d.rd", i), 0, 1'b0, 1'b0, 1'b1, 8'(i), 8'h00);
        end

        // Asynchronous reset in the middle of a burst, checked before the next edge.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        check_state("pre_reset", 2, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22);
        wr     = 1'b1;
        w_data = 8'h44;
        rd     = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_state("async_reset", 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        wr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset", 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fifo_stat
